// File: rtl/pipe_pkg.sv
// Shared pipeline package.
//  DATA_W / REG_AW : datapath and regfile address widths used across stages
//  WB_SEL_*        : encoding of the write-back source select
//  mem_wb_t        : contents of the MEM/WB pipeline register
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] waddr;
    logic              wena;
    logic [DATA_W-1:0] wdata;
  } mem_wb_t;

endpackage

// File: rtl/pipe_mem_wb.sv
// MEM/WB pipeline register plus write-back stage.
//
// Ports:
//  in_clk, in_rst          clock (rising edge) and asynchronous active-high reset
//  in_stall, in_flush      pipeline control (see below)
//  in_valid, in_pc         MEM-stage instruction valid flag and PC
//  in_rd_waddr/sel/wena    destination register, write-back source select, write enable
//  in_alu_result           ALU result from MEM
//  in_dmem_data            formatted dmem read data from MEM
//  out_rf_*                regfile write port
//  out_fwd_*               forwarding entry for EX (mirrors the regfile write port)
//  out_wb_pc/out_wb_valid  instruction currently in WB
//  out_retired_cnt         number of instructions retired through WB (wraps)
//
// Pipeline control: there is no valid/ready handshake. Every rising edge the
// register either clears to a bubble (in_flush), holds (in_stall), or loads
// the MEM stage (neither). Flush beats stall. in_valid=0 loads as a bubble.
// The retired counter only advances on a load with in_valid=1.
module pipe_mem_wb
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_stall,
  input  logic              in_flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [REG_AW-1:0] in_rd_waddr,
  input  logic              in_rd_sel,
  input  logic              in_rd_wena,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_dmem_data,
  output logic              out_rf_wena,
  output logic [REG_AW-1:0] out_rf_waddr,
  output logic [DATA_W-1:0] out_rf_wdata,
  output logic              out_fwd_valid,
  output logic [REG_AW-1:0] out_fwd_addr,
  output logic [DATA_W-1:0] out_fwd_data,
  output logic [DATA_W-1:0] out_wb_pc,
  output logic              out_wb_valid,
  output logic [CNT_W-1:0]  out_retired_cnt
);

  mem_wb_t          wb_q;
  mem_wb_t          wb_d;
  logic [CNT_W-1:0] cnt_q;

  // Front end: resolve the write-back value and the $0 guard before the
  // register, so WB drives the regfile with no logic after the flops.
  always_comb begin
    wb_d       = '0;
    wb_d.valid = in_valid;
    wb_d.pc    = in_pc;
    wb_d.waddr = in_rd_waddr;
    wb_d.wena  = in_valid & in_rd_wena & (in_rd_waddr != '0);
    wb_d.wdata = (in_rd_sel == WB_SEL_MEM) ? in_dmem_data : in_alu_result;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      wb_q  <= '0;
      cnt_q <= '0;
    end else if (in_flush) begin
      wb_q <= '0;
    end else if (!in_stall) begin
      wb_q <= wb_d;
      if (in_valid) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A held stall re-presents the same write every cycle; the regfile write
  // is idempotent, so nothing here suppresses the repeat.
  assign out_rf_wena     = wb_q.wena;
  assign out_rf_waddr    = wb_q.waddr;
  assign out_rf_wdata    = wb_q.wdata;
  assign out_fwd_valid   = wb_q.wena;
  assign out_fwd_addr    = wb_q.waddr;
  assign out_fwd_data    = wb_q.wdata;
  assign out_wb_pc       = wb_q.pc;
  assign out_wb_valid    = wb_q.valid;
  assign out_retired_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_mem_wb.sv
module tb_pipe_mem_wb;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              stall, flush, valid, rd_sel, rd_wena;
  logic [DATA_W-1:0] pc, alu, dmem;
  logic [REG_AW-1:0] rd;

  logic              rf_wena, fwd_valid, wb_valid;
  logic [REG_AW-1:0] rf_waddr, fwd_addr;
  logic [DATA_W-1:0] rf_wdata, fwd_data, wb_pc;
  logic [31:0]       cnt;

  logic              s_rf_wena, s_fwd_valid, s_wb_valid;
  logic [REG_AW-1:0] s_rf_waddr, s_fwd_addr;
  logic [DATA_W-1:0] s_rf_wdata, s_fwd_data, s_wb_pc;
  logic [3:0]        s_cnt;

  pipe_mem_wb dut (
    .in_clk(clk), .in_rst(rst), .in_stall(stall), .in_flush(flush),
    .in_valid(valid), .in_pc(pc), .in_rd_waddr(rd), .in_rd_sel(rd_sel),
    .in_rd_wena(rd_wena), .in_alu_result(alu), .in_dmem_data(dmem),
    .out_rf_wena(rf_wena), .out_rf_waddr(rf_waddr), .out_rf_wdata(rf_wdata),
    .out_fwd_valid(fwd_valid), .out_fwd_addr(fwd_addr), .out_fwd_data(fwd_data),
    .out_wb_pc(wb_pc), .out_wb_valid(wb_valid), .out_retired_cnt(cnt)
  );

  // Narrow-counter build for the wrap check; shares all stimulus.
  pipe_mem_wb #(.CNT_W(4)) dut4 (
    .in_clk(clk), .in_rst(rst), .in_stall(stall), .in_flush(flush),
    .in_valid(valid), .in_pc(pc), .in_rd_waddr(rd), .in_rd_sel(rd_sel),
    .in_rd_wena(rd_wena), .in_alu_result(alu), .in_dmem_data(dmem),
    .out_rf_wena(s_rf_wena), .out_rf_waddr(s_rf_waddr), .out_rf_wdata(s_rf_wdata),
    .out_fwd_valid(s_fwd_valid), .out_fwd_addr(s_fwd_addr), .out_fwd_data(s_fwd_data),
    .out_wb_pc(s_wb_pc), .out_wb_valid(s_wb_valid), .out_retired_cnt(s_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check the full WB/forwarding view against one expected entry.
  task automatic check_wb(input string tag, input logic e_wena, input logic [REG_AW-1:0] e_addr,
                          input logic [DATA_W-1:0] e_data, input logic [DATA_W-1:0] e_pc,
                          input logic e_valid, input logic [31:0] e_cnt);
    check({tag, ".rf_wena"},   64'(rf_wena),   64'(e_wena));
    check({tag, ".rf_waddr"},  64'(rf_waddr),  64'(e_addr));
    check({tag, ".rf_wdata"},  64'(rf_wdata),  64'(e_data));
    check({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(e_wena));
    check({tag, ".fwd_addr"},  64'(fwd_addr),  64'(e_addr));
    check({tag, ".fwd_data"},  64'(fwd_data),  64'(e_data));
    check({tag, ".wb_pc"},     64'(wb_pc),     64'(e_pc));
    check({tag, ".wb_valid"},  64'(wb_valid),  64'(e_valid));
    check({tag, ".cnt"},       64'(cnt),       64'(e_cnt));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [DATA_W-1:0] p, input logic [REG_AW-1:0] r,
                       input logic sel, input logic we, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    valid = v; pc = p; rd = r; rd_sel = sel; rd_wena = we; alu = a; dmem = d;
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    stall = 0; flush = 0;
    // 1. reset held during a valid load
    drive(1, 32'h0000_0100, 5'd3, 0, 1, 32'h0000_AAAA, 32'h0);
    step(); step();
    check_wb("reset_hold", 0, 0, 0, 0, 0, 0);
    check("reset_hold.cnt4", 64'(s_cnt), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    #1;
    check("reset_rel.cnt", 64'(cnt), 64'd0);

    // 2. ALU write-back (dmem differs so a wrong select shows)
    drive(1, 32'h0000_0400, 5'd8, 0, 1, 32'h0000_1234, 32'hDEAD_BEEF);
    step();
    check_wb("alu_wb", 1, 5'd8, 32'h0000_1234, 32'h0000_0400, 1, 1);

    // 3. load write-back
    drive(1, 32'h0000_0404, 5'd9, 1, 1, 32'h1001_0004, 32'hFFFF_FF80);
    step();
    check_wb("mem_wb", 1, 5'd9, 32'hFFFF_FF80, 32'h0000_0404, 1, 2);

    // 4. write to $0: retires but never writes
    drive(1, 32'h0000_0408, 5'd0, 0, 1, 32'h0000_0055, 32'h0);
    step();
    check("zero.rf_wena", 64'(rf_wena), 64'd0);
    check("zero.fwd_valid", 64'(fwd_valid), 64'd0);
    check("zero.wb_valid", 64'(wb_valid), 64'd1);
    check("zero.cnt", 64'(cnt), 64'd3);

    // valid instruction without a write
    drive(1, 32'h0000_040C, 5'd7, 0, 0, 32'h0000_0077, 32'h0);
    step();
    check("nowr.rf_wena", 64'(rf_wena), 64'd0);
    check("nowr.wb_valid", 64'(wb_valid), 64'd1);
    check("nowr.cnt", 64'(cnt), 64'd4);

    // in_valid=0 load is a bubble even with wena set
    drive(0, 32'h0000_0410, 5'd6, 0, 1, 32'h0000_0066, 32'h0);
    step();
    check("bubble.rf_wena", 64'(rf_wena), 64'd0);
    check("bubble.wb_valid", 64'(wb_valid), 64'd0);
    check("bubble.cnt", 64'(cnt), 64'd4);

    // 5. load rd=5, then stall 3 cycles with different inputs presented
    drive(1, 32'h0000_0500, 5'd5, 0, 1, 32'h0000_5555, 32'h0);
    step();
    check_wb("ld5", 1, 5'd5, 32'h0000_5555, 32'h0000_0500, 1, 5);
    drive(1, 32'h0000_0504, 5'd12, 1, 1, 32'h0000_9999, 32'h0000_8888);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_wb($sformatf("stall%0d", i), 1, 5'd5, 32'h0000_5555, 32'h0000_0500, 1, 5);
    end
    // flush wins over stall
    flush = 1;
    step();
    check_wb("flush_stall", 0, 0, 0, 0, 0, 5);
    // flush alone with a valid instruction presented
    stall = 0;
    step();
    check_wb("flush", 0, 0, 0, 0, 0, 5);
    flush = 0;
    step();
    check_wb("resume", 1, 5'd12, 32'h0000_8888, 32'h0000_0504, 1, 6);

    // asynchronous reset mid-operation: outputs drop with no clock edge
    rst = 1;
    #1;
    check("async_rst.rf_wena", 64'(rf_wena), 64'd0);
    check("async_rst.wb_valid", 64'(wb_valid), 64'd0);
    check("async_rst.cnt", 64'(cnt), 64'd0);
    step();
    check("async_rst.hold_wena", 64'(rf_wena), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    #1;

    // 6. counter wrap on the 4-bit build: 16 retires -> 0, 17 -> 1
    for (int i = 0; i < 17; i++) begin
      drive(1, 32'h0000_1000 + 32'(i * 4), 5'(i + 1), 0, 1, 32'(i), 32'h0);
      step();
      if (i == 14) check("wrap.cnt4_at15", 64'(s_cnt), 64'd15);
      if (i == 15) check("wrap.cnt4_at16", 64'(s_cnt), 64'd0);
    end
    check("wrap.cnt4", 64'(s_cnt), 64'd1);
    check("wrap.cnt32", 64'(cnt), 64'd17);
    check("wrap.last_waddr", 64'(rf_waddr), 64'd17);
    check("wrap.last_wdata", 64'(rf_wdata), 64'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
